// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - binary32 field layout, unpacked operand type and special-case encoding
package fp_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIG_W    = MAN_W + 1;
    localparam int ALIGN_W  = SIG_W + 3;
    localparam int FRAC_LSB = 0;
    localparam int EXP_LSB  = MAN_W;
    localparam int SIGN_BIT = EXP_W + MAN_W;

    typedef logic [1:0] special_t;
    localparam special_t FP_NORMAL = 2'b00;
    localparam special_t FP_INF    = 2'b01;
    localparam special_t FP_NAN    = 2'b10;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_nan;
        logic             is_inf;
    } fp_unpacked_t;

    // Denormals take effective exponent 1 with a zero hidden bit.
    function automatic fp_unpacked_t fp_unpack(input logic [SIGN_BIT:0] x);
        fp_unpacked_t     u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e        = x[EXP_LSB +: EXP_W];
        f        = x[FRAC_LSB +: MAN_W];
        u.sign   = x[SIGN_BIT];
        u.exp    = (e == '0) ? EXP_W'(1) : e;
        u.sig    = {(e != '0), f};
        u.is_nan = (e == '1) && (f != '0);
        u.is_inf = (e == '1) && (f == '0);
        return u;
    endfunction
endpackage

// File: rtl/fp_align_shifter.sv
// rtl/fp_align_shifter.sv - logarithmic right shifter producing the aligned significand with guard/round/sticky
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [7:0]       shift,
    output logic [SIG_W-1:0] mant,
    output logic [2:0]       grs
);
    logic [ALIGN_W-1:0] v;
    logic               sticky;

    always_comb begin
        v      = {sig, 3'b000};
        sticky = 1'b0;
        // Bits falling off the bottom of each stage are folded into sticky.
        for (int k = 0; k < 5; k++) begin
            if (shift[k]) begin
                sticky = sticky | (|(v & ((ALIGN_W'(1) << (1 << k)) - ALIGN_W'(1))));
                v      = v >> (1 << k);
            end
        end
        if (shift >= 8'(ALIGN_W)) begin
            mant = '0;
            grs  = {2'b00, |sig};
        end else begin
            mant = v[ALIGN_W-1:3];
            grs  = {v[2:1], v[0] | sticky};
        end
    end
endmodule

// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - two-stage compare/swap and alignment pipeline feeding the mantissa adder
module fp_align_stage #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAN_W:0]         out_mant_big,
    output logic [MAN_W:0]         out_mant_small,
    output logic [2:0]             out_grs,
    output logic [EXP_W-1:0]       out_exp,
    output logic                   out_sign,
    output logic                   out_eff_sub,
    output logic [1:0]             out_special
);
    import fp_pkg::fp_unpacked_t;
    import fp_pkg::fp_unpack;
    import fp_pkg::special_t;
    import fp_pkg::FP_NORMAL;
    import fp_pkg::FP_INF;
    import fp_pkg::FP_NAN;

    fp_unpacked_t     ua, ub;
    logic             sign_b, eff_sub, a_big;
    logic [MAN_W:0]   c_big, c_small;
    logic [EXP_W-1:0] c_exp, c_d;
    logic             c_sign;
    special_t         c_special;

    always_comb begin
        ua      = fp_unpack(in_a);
        ub      = fp_unpack(in_b);
        sign_b  = ub.sign ^ in_sub;
        eff_sub = ua.sign ^ sign_b;
        // Ties go to A so the aligned small significand never exceeds the big one.
        a_big   = (ua.exp > ub.exp) || ((ua.exp == ub.exp) && (ua.sig >= ub.sig));
        if (a_big) begin
            c_big   = ua.sig;
            c_small = ub.sig;
            c_exp   = ua.exp;
            c_d     = ua.exp - ub.exp;
            c_sign  = ua.sign;
        end else begin
            c_big   = ub.sig;
            c_small = ua.sig;
            c_exp   = ub.exp;
            c_d     = ub.exp - ua.exp;
            c_sign  = sign_b;
        end
        c_special = FP_NORMAL;
        if (ua.is_nan || ub.is_nan) begin
            c_special = FP_NAN;
        end else if (ua.is_inf && ub.is_inf && eff_sub) begin
            c_special = FP_NAN;
        end else if (ua.is_inf || ub.is_inf) begin
            c_special = FP_INF;
            c_sign    = ua.is_inf ? ua.sign : sign_b;
        end
    end

    logic             s1_valid, s1_sign, s1_eff_sub;
    logic [MAN_W:0]   s1_mant_big, s1_mant_small;
    logic [EXP_W-1:0] s1_exp, s1_d;
    special_t         s1_special;

    logic             s2_valid, s2_sign, s2_eff_sub;
    logic [MAN_W:0]   s2_mant_big, s2_mant_small;
    logic [2:0]       s2_grs;
    logic [EXP_W-1:0] s2_exp;
    special_t         s2_special;

    logic             s1_adv;
    logic [MAN_W:0]   sh_mant;
    logic [2:0]       sh_grs;

    fp_align_shifter u_shifter (
        .sig   (s1_mant_small),
        .shift (s1_d),
        .mant  (sh_mant),
        .grs   (sh_grs)
    );

    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s1_adv);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_eff_sub    <= 1'b0;
            s1_mant_big   <= '0;
            s1_mant_small <= '0;
            s1_exp        <= '0;
            s1_d          <= '0;
            s1_special    <= FP_NORMAL;
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_eff_sub    <= 1'b0;
            s2_mant_big   <= '0;
            s2_mant_small <= '0;
            s2_grs        <= '0;
            s2_exp        <= '0;
            s2_special    <= FP_NORMAL;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign       <= c_sign;
                    s1_eff_sub    <= eff_sub;
                    s1_mant_big   <= c_big;
                    s1_mant_small <= c_small;
                    s1_exp        <= c_exp;
                    s1_d          <= c_d;
                    s1_special    <= c_special;
                end
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign       <= s1_sign;
                    s2_eff_sub    <= s1_eff_sub;
                    s2_mant_big   <= s1_mant_big;
                    s2_mant_small <= sh_mant;
                    s2_grs        <= sh_grs;
                    s2_exp        <= s1_exp;
                    s2_special    <= s1_special;
                end
            end
        end
    end

    assign out_valid      = s2_valid;
    assign out_mant_big   = s2_mant_big;
    assign out_mant_small = s2_mant_small;
    assign out_grs        = s2_grs;
    assign out_exp        = s2_exp;
    assign out_sign       = s2_sign;
    assign out_eff_sub    = s2_eff_sub;
    assign out_special    = s2_special;
endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - directed-vector bench for the FP align stage
module tb_fp_align_stage;
    logic        clk, rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [23:0] out_mant_big, out_mant_small;
    logic [2:0]  out_grs;
    logic [7:0]  out_exp;
    logic        out_sign, out_eff_sub;
    logic [1:0]  out_special;

    int total = 0;
    int bad   = 0;

    fp_align_stage dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_sub         (in_sub),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mant_big   (out_mant_big),
        .out_mant_small (out_mant_small),
        .out_grs        (out_grs),
        .out_exp        (out_exp),
        .out_sign       (out_sign),
        .out_eff_sub    (out_eff_sub),
        .out_special    (out_special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [23:0] e_big, input logic [23:0] e_small, input logic [2:0] e_grs,
                       input logic [7:0] e_exp, input logic e_sign, input logic e_eff, input logic [1:0] e_spec);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".big"},   32'(out_mant_big), 32'(e_big));
        check({tag, ".small"}, 32'(out_mant_small), 32'(e_small));
        check({tag, ".grs"},   32'(out_grs), 32'(e_grs));
        check({tag, ".exp"},   32'(out_exp), 32'(e_exp));
        check({tag, ".sign"},  32'(out_sign), 32'(e_sign));
        check({tag, ".eff"},   32'(out_eff_sub), 32'(e_eff));
        check({tag, ".spec"},  32'(out_special), 32'(e_spec));
        @(posedge clk); #1;
        check({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int sent, got, last_cyc, first_k, n_out;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.big", 32'(out_mant_big), 32'd0);
        check("rst.exp", 32'(out_exp), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        vec("equal",   32'h3F800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 3'b000, 8'd127, 1'b0, 1'b0, 2'b00);
        vec("shift1",  32'h3F800000, 32'h3F400001, 1'b0, 24'h800000, 24'h600000, 3'b100, 8'd127, 1'b0, 1'b0, 2'b00);
        vec("large",   32'h30800000, 32'h3F800000, 1'b0, 24'h800000, 24'h000000, 3'b001, 8'd127, 1'b0, 1'b0, 2'b00);
        vec("infsub",  32'h7F800000, 32'hFF800000, 1'b0, 24'h800000, 24'h800000, 3'b000, 8'd255, 1'b0, 1'b1, 2'b10);
        vec("inf",     32'h7F800000, 32'h3F800000, 1'b0, 24'h800000, 24'h000000, 3'b001, 8'd255, 1'b0, 1'b0, 2'b01);
        vec("nan",     32'h7FC00000, 32'h3F800000, 1'b0, 24'hC00000, 24'h000000, 3'b001, 8'd255, 1'b0, 1'b0, 2'b10);
        vec("sub_a",   32'h40000000, 32'h3F800000, 1'b1, 24'h800000, 24'h400000, 3'b000, 8'd128, 1'b0, 1'b1, 2'b00);
        vec("sub_b",   32'h3F800000, 32'h40400000, 1'b1, 24'hC00000, 24'h400000, 3'b000, 8'd128, 1'b1, 1'b1, 2'b00);
        vec("denorm",  32'h00000001, 32'h00000003, 1'b0, 24'h000003, 24'h000001, 3'b000, 8'd1,   1'b0, 1'b0, 2'b00);
        vec("rs3",     32'h3F800000, 32'h3E000003, 1'b0, 24'h800000, 24'h100000, 3'b011, 8'd127, 1'b0, 1'b0, 2'b00);
        vec("sticky5", 32'h3F800000, 32'h3D000003, 1'b0, 24'h800000, 24'h040000, 3'b001, 8'd127, 1'b0, 1'b0, 2'b00);

        // Backpressure: four pairs, out_ready low for the first four cycles.
        sent = 0; got = 0; last_cyc = -1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            out_ready = (cyc >= 4);
            in_valid  = (sent < 4);
            in_a      = {1'b0, 8'(127 + sent), 23'd0};
            in_b      = 32'h3F800000;
            in_sub    = 1'b0;
            #1;
            if (cyc == 2) begin
                check("bp.sent_before_stall", 32'(sent), 32'd2);
                check("bp.in_ready_low", 32'(in_ready), 32'd0);
            end
            if (cyc == 2 || cyc == 3) begin
                check("bp.hold_valid", 32'(out_valid), 32'd1);
                check("bp.hold_exp", 32'(out_exp), 32'd127);
                check("bp.hold_small", 32'(out_mant_small), 32'h800000);
            end
            if (cyc >= 4) begin
                check("bp.stream_valid", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    check("bp.order_exp", 32'(out_exp), 32'(127 + got));
                    check("bp.order_small", 32'(out_mant_small), 32'h800000 >> got);
                    got++;
                    last_cyc = cyc;
                end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp.count", 32'(got), 32'd4);
        check("bp.last_cycle", 32'(last_cyc), 32'd7);

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rmf.full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmf.out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        #1;
        check("rmf.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h3F800000; in_sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_out = 0; first_k = -1;
        for (int k = 1; k <= 6; k++) begin
            if (out_valid) begin
                n_out++;
                if (first_k < 0) first_k = k;
                check("rmf.exp", 32'(out_exp), 32'd128);
            end
            @(posedge clk); #1;
        end
        check("rmf.count", 32'(n_out), 32'd1);
        check("rmf.latency", 32'(first_k), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
